// File: rtl/cla_serial_adder.sv
// Digit-serial carry-lookahead adder/subtractor: CHUNK bits per cycle, LSB chunk first,
// with a registered carry between chunks and a valid/ready handshake on both sides.
module cla_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("cla_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    // Current chunk slice and its lookahead carries
    int unsigned      base;
    logic [CHUNK-1:0] ca, cb, g, p, s;
    logic [CHUNK:0]   c;
    logic             prod;

    always_comb begin
        base = 32'(cnt_q) * CHUNK;
        ca   = CHUNK'(a_q >> base);
        cb   = CHUNK'(b_q >> base);
        g    = ca & cb;
        p    = ca ^ cb;
        c    = '0;
        c[0] = carry_q;
        prod = 1'b0;
        // Sum-of-products lookahead: c[k+1] = g[k] | p[k]g[k-1] | ... | p[k..0]c[0]
        for (int k = 0; k < int'(CHUNK); k++) begin
            c[k+1] = g[k];
            prod   = p[k];
            for (int j = k - 1; j >= 0; j--) begin
                c[k+1] = c[k+1] | (prod & g[j]);
                prod   = prod & p[j];
            end
            c[k+1] = c[k+1] | (prod & c[0]);
        end
        s = p ^ c[CHUNK-1:0];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub | carry_in;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d   = (sum_q & ~(WIDTH'({CHUNK{1'b1}}) << base)) | (WIDTH'(s) << base);
                carry_d = c[CHUNK];
                if (cnt_q == CW'(N - 1)) begin
                    carry_out_d = c[CHUNK];
                    overflow_d  = c[CHUNK] ^ c[CHUNK-1];
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed bench for cla_serial_adder: three parameterisations sharing clock, reset and operands.
module tb_cla_serial_adder;

    logic        clk;
    logic        rst;
    logic [31:0] a_in, b_in;
    logic        cin, sub, in_valid, out_ready;
    int          sel;

    logic        iv16, iv32, iv8;
    logic [15:0] sum16;
    logic [31:0] sum32;
    logic [7:0]  sum8;
    logic        co16, co32, co8, ov16, ov32, ov8;
    logic        ir16, ir32, ir8, vo16, vo32, vo8;

    logic [31:0] r_sum;
    logic        r_co, r_ov, r_ir, r_vo;

    int checks = 0;
    int errors = 0;

    assign iv16 = in_valid && (sel == 0);
    assign iv32 = in_valid && (sel == 1);
    assign iv8  = in_valid && (sel == 2);

    cla_serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .a(a_in[15:0]), .b(b_in[15:0]), .carry_in(cin), .sub(sub),
        .in_valid(iv16), .in_ready(ir16), .sum(sum16), .carry_out(co16), .overflow(ov16),
        .out_valid(vo16), .out_ready(out_ready)
    );

    cla_serial_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst(rst), .a(a_in), .b(b_in), .carry_in(cin), .sub(sub),
        .in_valid(iv32), .in_ready(ir32), .sum(sum32), .carry_out(co32), .overflow(ov32),
        .out_valid(vo32), .out_ready(out_ready)
    );

    cla_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .a(a_in[7:0]), .b(b_in[7:0]), .carry_in(cin), .sub(sub),
        .in_valid(iv8), .in_ready(ir8), .sum(sum8), .carry_out(co8), .overflow(ov8),
        .out_valid(vo8), .out_ready(out_ready)
    );

    always_comb begin
        case (sel)
            1: begin
                r_sum = sum32; r_co = co32; r_ov = ov32; r_ir = ir32; r_vo = vo32;
            end
            2: begin
                r_sum = 32'(sum8); r_co = co8; r_ov = ov8; r_ir = ir8; r_vo = vo8;
            end
            default: begin
                r_sum = 32'(sum16); r_co = co16; r_ov = ov16; r_ir = ir16; r_vo = vo16;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!r_vo && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb, input logic [31:0] es,
                          input logic eco, input logic eov, input int lat, input string tag);
        int cyc;
        @(negedge clk);
        sel = s; a_in = a; b_in = b; cin = ci; sub = sb; in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(r_ir), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(cyc);
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        chk({tag, "_sum"}, r_sum, es);
        chk({tag, "_carry_out"}, 32'(r_co), 32'(eco));
        chk({tag, "_overflow"}, 32'(r_ov), 32'(eov));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(r_vo), 32'd0);
        chk({tag, "_idle_ready"}, 32'(r_ir), 32'd1);
    endtask

    initial begin
        int cyc;
        logic seen;
        rst = 1'b1; a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; sel = 0;
        repeat (2) @(negedge clk);
        chk("reset_sum", r_sum, 32'd0);
        chk("reset_carry_out", 32'(r_co), 32'd0);
        chk("reset_overflow", 32'(r_ov), 32'd0);
        chk("reset_out_valid", 32'(r_vo), 32'd0);
        chk("reset_in_ready", 32'(r_ir), 32'd1);
        rst = 1'b0;

        run_op(0, 32'd10, 32'd22, 1'b0, 1'b0, 32'd32, 1'b0, 1'b0, 4, "add");
        run_op(0, 32'd10, 32'd22, 1'b1, 1'b0, 32'd33, 1'b0, 1'b0, 4, "add_cin");
        run_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, 4, "ripple");
        run_op(0, 32'd10, 32'd22, 1'b1, 1'b1, 32'hFFF4, 1'b0, 1'b0, 4, "sub_neg");
        run_op(0, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, 4, "sub_ovf");
        run_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 4, "add_ovf");

        // Backpressure: result held in DONE while a competing request is presented
        @(negedge clk);
        sel = 0; a_in = 32'd100; b_in = 32'd23; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(cyc);
        chk("bp_latency", 32'(cyc), 32'd4);
        a_in = 32'd5; b_in = 32'd5; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_sum_stable", r_sum, 32'd123);
            chk("bp_out_valid", 32'(r_vo), 32'd1);
            chk("bp_in_ready", 32'(r_ir), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(r_vo), 32'd0);
        chk("bp_release_ready", 32'(r_ir), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_accepted", 32'(r_ir), 32'd0);
        wait_valid(cyc);
        chk("bp_next_latency", 32'(cyc), 32'd4);
        chk("bp_next_sum", r_sum, 32'd10);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during the second BUSY cycle discards the operation
        @(negedge clk);
        a_in = 32'h1234; b_in = 32'h1111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_busy_sum", r_sum, 32'd0);
        chk("rst_busy_out_valid", 32'(r_vo), 32'd0);
        chk("rst_busy_in_ready", 32'(r_ir), 32'd1);
        chk("rst_busy_carry_out", 32'(r_co), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (r_vo) seen = 1'b1;
        end
        chk("rst_busy_no_valid", 32'(seen), 32'd0);

        run_op(1, 32'd10, 32'd22, 1'b0, 1'b0, 32'd32, 1'b0, 1'b0, 4, "w32");
        run_op(2, 32'd10, 32'd22, 1'b0, 1'b0, 32'd32, 1'b0, 1'b0, 1, "w8");
        run_op(2, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 1, "w8_ovf");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
